// File: rtl/snapshot_pkg.sv
// Shared types and helpers for the snapshot capture engine.
package snapshot_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CIRC    = 1'b1;

  // Lane-select width for a DATA_W word read back BUS_W bits at a time.
  function automatic int lane_w(input int data_w, input int bus_w);
    if (data_w / bus_w > 1) begin
      return $clog2(data_w / bus_w);
    end else begin
      return 0;
    end
  endfunction

endpackage

// File: rtl/snapshot_dp_ram.sv
// Simple dual-port capture buffer: one write port, one registered read port,
// read-first on a same-address collision.
module snapshot_dp_ram #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Write and registered read share one edge, so a colliding read sees old data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/snapshot_capture_ctrl.sv
// Snapshot capture engine: one-shot or circular recording into a private
// buffer, with a two-cycle lane-sliced readback port.
module snapshot_capture_ctrl
  import snapshot_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 12,
  parameter int BUS_W  = 32,
  parameter int LANE_W = lane_w(DATA_W, BUS_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     trig,
  input  logic                     circ,
  input  logic [ADDR_W-1:0]        post_len,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_we,
  input  logic                     rd_en,
  input  logic [ADDR_W+LANE_W-1:0] rd_addr,
  output logic [BUS_W-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     wrapped,
  output logic [ADDR_W-1:0]        trig_addr,
  output logic [ADDR_W-1:0]        end_addr
);

  localparam int NLANES = DATA_W / BUS_W;
  localparam int LSEL_W = (LANE_W > 0) ? LANE_W : 1;
  localparam int NSLOT  = 1 << LANE_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] end_addr_q, end_addr_d;
  logic              circ_q, circ_d;
  logic              wrapped_q, wrapped_d;
  logic              busy_q, done_q;
  logic              we_s;

  logic [DATA_W-1:0] ram_rdata_s;
  logic [LSEL_W-1:0] lane_s, lane_q;
  logic              rv1_q, rd_valid_q;
  logic [BUS_W-1:0]  rd_data_q, rd_slice_s;
  logic [BUS_W-1:0]  lanes_s [NSLOT];

  // Capture FSM next-state, write strobe and status updates.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rem_d       = rem_q;
    trig_addr_d = trig_addr_q;
    end_addr_d  = end_addr_q;
    circ_d      = circ_q;
    wrapped_d   = wrapped_q;
    we_s        = 1'b0;
    if (arm) begin
      state_d     = S_ARMED;
      wptr_d      = '0;
      trig_addr_d = '0;
      end_addr_d  = '0;
      wrapped_d   = 1'b0;
      circ_d      = circ;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (circ_q == MODE_CIRC) begin
            we_s = din_we;
            if (trig) begin
              // post_len is ADDR_W wide, so it can never exceed depth-1.
              trig_addr_d = wptr_q;
              if (post_len <= ADDR_W'(din_we)) begin
                rem_d   = '0;
                state_d = S_DONE;
              end else begin
                rem_d   = post_len - ADDR_W'(din_we);
                state_d = S_CAPTURE;
              end
            end else begin
              state_d = S_ARMED;
            end
          end else begin
            if (trig) begin
              we_s    = din_we;
              state_d = S_CAPTURE;
            end else begin
              state_d = S_ARMED;
            end
          end
        end
        S_CAPTURE: begin
          we_s = din_we;
          if (din_we) begin
            if (circ_q == MODE_ONESHOT) begin
              if (wptr_q == '1) begin
                state_d = S_DONE;
              end else begin
                state_d = S_CAPTURE;
              end
            end else begin
              rem_d = rem_q - ADDR_W'(1);
              if (rem_q == ADDR_W'(1)) begin
                state_d = S_DONE;
              end else begin
                state_d = S_CAPTURE;
              end
            end
          end else begin
            state_d = S_CAPTURE;
          end
        end
        S_IDLE:  state_d = S_IDLE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
      if (we_s) begin
        end_addr_d = wptr_q;
        wptr_d     = wptr_q + ADDR_W'(1);
        if ((wptr_q == '1) && (circ_q == MODE_CIRC)) begin
          wrapped_d = 1'b1;
        end else begin
          wrapped_d = wrapped_q;
        end
      end else begin
        end_addr_d = end_addr_q;
      end
    end
  end

  // Capture state and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rem_q       <= '0;
      trig_addr_q <= '0;
      end_addr_q  <= '0;
      circ_q      <= MODE_ONESHOT;
      wrapped_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rem_q       <= rem_d;
      trig_addr_q <= trig_addr_d;
      end_addr_q  <= end_addr_d;
      circ_q      <= circ_d;
      wrapped_q   <= wrapped_d;
      busy_q      <= (state_d == S_ARMED) || (state_d == S_CAPTURE);
      done_q      <= (state_d == S_DONE);
    end
  end

  snapshot_dp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (wptr_q),
    .wdata (din),
    .re    (rd_en),
    .raddr (rd_addr[ADDR_W+LANE_W-1 -: ADDR_W]),
    .rdata (ram_rdata_s)
  );

  // Lane 0 is the most significant slice of the stored word.
  for (genvar g = 0; g < NSLOT; g++) begin : g_lane
    if (g < NLANES) begin : g_used
      assign lanes_s[g] = ram_rdata_s[DATA_W-1-g*BUS_W -: BUS_W];
    end else begin : g_unused
      assign lanes_s[g] = '0;
    end
  end

  if (LANE_W > 0) begin : g_sel
    assign lane_s     = rd_addr[LSEL_W-1:0];
    assign rd_slice_s = lanes_s[lane_q];
  end else begin : g_nosel
    assign lane_s     = '0;
    assign rd_slice_s = lanes_s[0];
  end

  // Readback pipeline: RAM read stage, then registered lane mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rv1_q      <= 1'b0;
      lane_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rv1_q      <= rd_en;
      rd_valid_q <= rv1_q;
      if (rd_en) begin
        lane_q <= lane_s;
      end
      if (rv1_q) begin
        rd_data_q <= rd_slice_s;
      end
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wrapped   = wrapped_q;
  assign trig_addr = trig_addr_q;
  assign end_addr  = end_addr_q;

endmodule

// File: tb/tb_snapshot_capture_ctrl.sv
// Directed self-checking bench for snapshot_capture_ctrl (128-bit words, 16 deep, 32-bit bus).
module tb_snapshot_capture_ctrl;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 4;
  localparam int BUS_W  = 32;
  localparam int LANE_W = 2;

  logic                     clk;
  logic                     rst;
  logic                     arm;
  logic                     trig;
  logic                     circ;
  logic [ADDR_W-1:0]        post_len;
  logic [DATA_W-1:0]        din;
  logic                     din_we;
  logic                     rd_en;
  logic [ADDR_W+LANE_W-1:0] rd_addr;
  logic [BUS_W-1:0]         rd_data;
  logic                     rd_valid;
  logic                     busy;
  logic                     done;
  logic                     wrapped;
  logic [ADDR_W-1:0]        trig_addr;
  logic [ADDR_W-1:0]        end_addr;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] junk;
  logic [BUS_W-1:0]  rdv;
  logic              v1, v2;
  int                valid_cnt;

  snapshot_capture_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BUS_W  (BUS_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .trig      (trig),
    .circ      (circ),
    .post_len  (post_len),
    .din       (din),
    .din_we    (din_we),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .done      (done),
    .wrapped   (wrapped),
    .trig_addr (trig_addr),
    .end_addr  (end_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic c);
    arm  = 1'b1;
    circ = c;
    step();
    arm  = 1'b0;
    circ = 1'b0;
  endtask

  task automatic rd_word(input logic [5:0] a, output logic [31:0] d, output logic va, output logic vb);
    rd_en   = 1'b1;
    rd_addr = a;
    step();
    rd_en = 1'b0;
    va    = rd_valid;
    step();
    vb = rd_valid;
    d  = rd_data;
  endtask

  function automatic logic [127:0] rep8(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic logic [127:0] cw(input int i);
    logic [31:0] u;
    u = i;
    return {32'h1000_0000 + u, 32'h2000_0000 + u, 32'h3000_0000 + u, 32'h4000_0000 + u};
  endfunction

  function automatic logic [127:0] fw(input int i);
    logic [31:0] u;
    u = i * 16;
    return {32'hC0DE_0000 + u, 32'hC0DE_0001 + u, 32'hC0DE_0002 + u, 32'hC0DE_0003 + u};
  endfunction

  initial begin
    rst = 1'b1; arm = 1'b0; trig = 1'b0; circ = 1'b0; post_len = '0;
    din = '0; din_we = 1'b0; rd_en = 1'b0; rd_addr = '0;
    junk = {4{32'hDEAD_BEEF}};
    step();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_wrapped", wrapped, 1'b0);
    check_eq("rst_trig_addr", trig_addr, 4'd0);
    check_eq("rst_end_addr", end_addr, 4'd0);
    check_eq("rst_rd_valid", rd_valid, 1'b0);
    check_eq("rst_rd_data", rd_data, 32'd0);
    rst = 1'b0;
    step();

    // One-shot fill
    do_arm(1'b0);
    check_eq("os_armed_busy", busy, 1'b1);
    check_eq("os_armed_done", done, 1'b0);
    din = junk; din_we = 1'b1; step(); din_we = 1'b0;
    trig = 1'b1; step(); trig = 1'b0;
    check_eq("os_capture_busy", busy, 1'b1);
    for (int i = 0; i < 16; i++) begin
      din = rep8(8'(i)); din_we = 1'b1; step();
      if (i == 14) check_eq("os_not_done_w14", done, 1'b0);
    end
    din_we = 1'b0;
    check_eq("os_done", done, 1'b1);
    check_eq("os_busy_clr", busy, 1'b0);
    check_eq("os_end_addr", end_addr, 4'd15);
    check_eq("os_wrapped", wrapped, 1'b0);
    check_eq("os_trig_addr", trig_addr, 4'd0);
    din = junk; din_we = 1'b1; step(); din_we = 1'b0;
    check_eq("os_done_nowrite_end", end_addr, 4'd15);
    rd_word({4'd5, 2'd0}, rdv, v1, v2);
    check_eq("os_rd_lat1_invalid", v1, 1'b0);
    check_eq("os_rd_lat2_valid", v2, 1'b1);
    check_eq("os_rd_w5_l0", rdv, 32'h0505_0505);
    rd_word({4'd15, 2'd3}, rdv, v1, v2);
    check_eq("os_rd_w15_l3", rdv, 32'h0F0F_0F0F);

    // Circular wrap
    do_arm(1'b1);
    for (int i = 0; i < 20; i++) begin
      din = cw(i); din_we = 1'b1; step();
      if (i == 14) check_eq("circ_wrapped_pre", wrapped, 1'b0);
      if (i == 15) check_eq("circ_wrapped_set", wrapped, 1'b1);
    end
    din_we = 1'b0;
    check_eq("circ_pre_end", end_addr, 4'd3);
    trig = 1'b1; post_len = 4'd6; din = cw(20); din_we = 1'b1; step();
    trig = 1'b0; din_we = 1'b0;
    check_eq("circ_trig_addr", trig_addr, 4'd4);
    check_eq("circ_trig_end", end_addr, 4'd4);
    check_eq("circ_trig_busy", busy, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      din = cw(21 + k); din_we = 1'b1; step(); din_we = 1'b0;
      if (k == 3) check_eq("circ_stall_not_done", done, 1'b0);
    end
    check_eq("circ_done", done, 1'b1);
    check_eq("circ_busy_clr", busy, 1'b0);
    check_eq("circ_end_addr", end_addr, 4'd9);
    check_eq("circ_wrapped", wrapped, 1'b1);
    check_eq("circ_trig_hold", trig_addr, 4'd4);
    rd_word({4'd3, 2'd0}, rdv, v1, v2);
    check_eq("circ_rd_w3_l0", rdv, 32'h1000_0013);
    rd_word({4'd9, 2'd3}, rdv, v1, v2);
    check_eq("circ_rd_w9_l3", rdv, 32'h4000_0019);
    rd_word({4'd10, 2'd1}, rdv, v1, v2);
    check_eq("circ_rd_w10_l1", rdv, 32'h2000_000A);

    // arm+trig same cycle from DONE, then zero-length post-trigger
    arm = 1'b1; circ = 1'b1; trig = 1'b1; post_len = 4'd0; din = junk; din_we = 1'b1; step();
    arm = 1'b0; circ = 1'b0; trig = 1'b0; din_we = 1'b0;
    check_eq("prio_busy", busy, 1'b1);
    check_eq("prio_done_clr", done, 1'b0);
    check_eq("prio_wrapped_clr", wrapped, 1'b0);
    check_eq("prio_end_clr", end_addr, 4'd0);
    for (int i = 0; i < 3; i++) begin
      din = cw(40 + i); din_we = 1'b1; step();
    end
    din_we = 1'b0;
    check_eq("zl_pre_end", end_addr, 4'd2);
    trig = 1'b1; post_len = 4'd0; step(); trig = 1'b0;
    check_eq("zl_done", done, 1'b1);
    check_eq("zl_trig_addr", trig_addr, 4'd3);
    check_eq("zl_end_addr", end_addr, 4'd2);
    rd_word({4'd0, 2'd0}, rdv, v1, v2);
    check_eq("prio_arm_din_ignored", rdv, 32'h1000_0028);
    do_arm(1'b1);
    trig = 1'b1; post_len = 4'd1; din = cw(50); din_we = 1'b1; step();
    trig = 1'b0; din_we = 1'b0;
    check_eq("pl1_done", done, 1'b1);
    check_eq("pl1_trig_addr", trig_addr, 4'd0);
    check_eq("pl1_end_addr", end_addr, 4'd0);

    // Reset mid-capture with reads in flight
    do_arm(1'b0);
    trig = 1'b1; din = rep8(8'hAA); din_we = 1'b1; step();
    trig = 1'b0; din = rep8(8'hBB); step(); din_we = 1'b0;
    check_eq("rst_mid_busy_pre", busy, 1'b1);
    rd_en = 1'b1; rd_addr = {4'd0, 2'd0}; step();
    rd_addr = {4'd1, 2'd0}; step(); rd_en = 1'b0;
    check_eq("rst_mid_rd_valid_pre", rd_valid, 1'b1);
    check_eq("rst_mid_rd_data_pre", rd_data, 32'hAAAA_AAAA);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_busy", busy, 1'b0);
    check_eq("rst_mid_done", done, 1'b0);
    check_eq("rst_mid_rd_valid", rd_valid, 1'b0);
    step();
    check_eq("rst_mid_inflight_dropped", rd_valid, 1'b0);
    rst = 1'b0;
    step();
    do_arm(1'b1);
    trig = 1'b1; post_len = 4'd2; din = cw(60); din_we = 1'b1; step();
    trig = 1'b0; din = cw(61); step(); din_we = 1'b0;
    check_eq("post_rst_done", done, 1'b1);
    check_eq("post_rst_trig_addr", trig_addr, 4'd0);
    check_eq("post_rst_end_addr", end_addr, 4'd1);
    check_eq("post_rst_wrapped", wrapped, 1'b0);

    // Back-to-back readback over every word/lane
    do_arm(1'b0);
    trig = 1'b1; din = fw(0); din_we = 1'b1; step(); trig = 1'b0;
    for (int i = 1; i < 16; i++) begin
      din = fw(i); step();
    end
    din_we = 1'b0;
    check_eq("pipe_fill_done", done, 1'b1);
    valid_cnt = 0;
    for (int c = 0; c <= 64; c++) begin
      rd_en = (c < 64); rd_addr = 6'(c); step();
      if (rd_valid) valid_cnt++;
      if (c >= 1) begin
        check_eq("pipe_rd_data", rd_data, 32'hC0DE_0000 + 32'((c - 1) / 4 * 16 + (c - 1) % 4));
      end else begin
        check_eq("pipe_first_invalid", rd_valid, 1'b0);
      end
    end
    rd_en = 1'b0;
    check_eq("pipe_valid_count", 32'(valid_cnt), 32'd64);
    step();
    check_eq("pipe_drain_invalid", rd_valid, 1'b0);

    // Same-word read and write in one cycle returns the old data
    do_arm(1'b1);
    din = rep8(8'h77); din_we = 1'b1; rd_en = 1'b1; rd_addr = {4'd0, 2'd0}; step();
    din_we = 1'b0; rd_en = 1'b0; step();
    check_eq("rf_valid", rd_valid, 1'b1);
    check_eq("rf_old_data", rd_data, 32'hC0DE_0000);
    rd_word({4'd0, 2'd0}, rdv, v1, v2);
    check_eq("rf_new_data", rdv, 32'h7777_7777);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
